param_fifo: RTL and testbench



---
 rtl/param_fifo_pkg.sv | 13 +
 rtl/param_fifo_out_stage.sv | 44 ++++
 rtl/param_fifo.sv | 100 ++++++++++
 tb/tb_param_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for param_fifo.
package param_fifo_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   function automatic bit af_level_ok(input int depth, input int level);
      return (level >= 1) && (level <= depth);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction
endpackage

// File: rtl/param_fifo_out_stage.sv
// Registered head-of-queue stage; refills from memory, or straight from the
// write port when memory is empty, so a stream passes through with no bubble.
module param_fifo_out_stage
   import param_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   input  logic             mem_empty,
   input  logic [WIDTH-1:0] mem_data,
   output logic             mem_rd,
   output logic             bypass,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   logic load;

   always_comb begin
      load   = !out_valid || out_ready;
      mem_rd = load && !mem_empty;
      bypass = load && mem_empty && push;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= !mem_empty || push;
      end
   end

   // Data register carries no reset; it is only meaningful with out_valid.
   always_ff @(posedge clk) begin
      if (mem_rd) begin
         out_data <= mem_data;
      end else if (bypass) begin
         out_data <= in_data;
      end
   end
endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous valid/ready FIFO with optional registered output
// stage, almost-full flag and sticky overflow flag.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  bit OUT_REG  = 1'b0,
   parameter  int AF_LEVEL = DEPTH - 2,
   localparam int ADDR_W   = $clog2(DEPTH),
   localparam int CNT_W    = ADDR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count,
   output logic             almost_full,
   output logic             overflow
);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $fatal(1, "param_fifo: DEPTH must be a power of two >= 2");
   end
   if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
      $fatal(1, "param_fifo: AF_LEVEL must lie in 1..DEPTH");
   end

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [WIDTH-1:0]  head;
   logic              push;
   logic              pop;
   logic              wr_en;
   logic              rd_en;

   // in_ready depends only on registered count, never on out_ready.
   assign in_ready    = count < FULL_CNT;
   assign almost_full = count >= AF_CNT;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign head        = mem[rd_ptr];

   if (OUT_REG) begin : g_out_reg
      logic mem_empty;
      logic bypass;

      // count includes the output-register entry, memory holds the rest.
      assign mem_empty = (count == {{ADDR_W{1'b0}}, out_valid});
      assign wr_en     = push && !bypass;

      param_fifo_out_stage #(.WIDTH(WIDTH)) out_stage_inst (
         .clk       (clk),
         .rst       (rst),
         .push      (push),
         .in_data   (in_data),
         .out_ready (out_ready),
         .mem_empty (mem_empty),
         .mem_data  (head),
         .mem_rd    (rd_en),
         .bypass    (bypass),
         .out_valid (out_valid),
         .out_data  (out_data)
      );
   end else begin : g_no_out_reg
      assign out_valid = (count != '0);
      assign out_data  = head;
      assign wr_en     = push;
      assign rd_en     = pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
         if (in_valid && !in_ready) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: default config (OUT_REG=0), DEPTH=4 with
// output register, and WIDTH=32/DEPTH=8 with output register and a scoreboard.
module tb_param_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Instance A: defaults
   logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af, a_ovf;
   logic [7:0] a_in_data, a_out_data;
   logic [4:0] a_count;
   // Instance B: DEPTH=4, OUT_REG=1
   logic       b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af, b_ovf;
   logic [7:0] b_in_data, b_out_data;
   logic [2:0] b_count;
   // Instance C: WIDTH=32, DEPTH=8, OUT_REG=1
   logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af, c_ovf;
   logic [31:0] c_in_data, c_out_data;
   logic [3:0]  c_count;

   param_fifo fifo_inst (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .count(a_count), .almost_full(a_af), .overflow(a_ovf));

   param_fifo #(.DEPTH(4), .OUT_REG(1'b1)) fifo_d4_inst (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .count(b_count), .almost_full(b_af), .overflow(b_ovf));

   param_fifo #(.WIDTH(32), .DEPTH(8), .OUT_REG(1'b1)) fifo_w32_inst (
      .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .count(c_count), .almost_full(c_af), .overflow(c_ovf));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [7:0]  words[20];
   int sent, got, cyc;
   logic push_m, pop_m;

   initial begin
      a_rst = 1; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
      b_rst = 1; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
      c_rst = 1; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
      tick(); tick();
      a_rst = 0; b_rst = 0; c_rst = 0;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_in_ready", a_in_ready, 1);
         check("idle_out_valid", a_out_valid, 0);
         check("idle_count", a_count, 0);
         check("idle_af", a_af, 0);
         check("idle_ovf", a_ovf, 0);
      end
      check("rst_b_out_valid", b_out_valid, 0);
      check("rst_b_count", b_count, 0);
      check("rst_c_out_valid", c_out_valid, 0);
      check("rst_c_in_ready", c_in_ready, 1);

      // Fill default FIFO with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         a_in_valid = 1; a_in_data = 8'(i);
         tick();
         check("fill_count", a_count, 32'(i));
         check("fill_af", a_af, (i >= 14) ? 1 : 0);
         check("fill_in_ready", a_in_ready, (i < 16) ? 1 : 0);
         if (i == 1) check("fill_latency_valid", a_out_valid, 1);
      end
      // Push into full FIFO: dropped, overflow set
      a_in_data = 8'hEE;
      tick();
      a_in_valid = 0;
      check("ovf_set", a_ovf, 1);
      check("ovf_count", a_count, 16);
      // Drain in order
      a_out_ready = 1;
      for (int i = 1; i <= 16; i++) begin
         check("drain_valid", a_out_valid, 1);
         check("drain_data", a_out_data, 32'(i));
         tick();
         check("drain_count", a_count, 32'(16 - i));
      end
      check("drain_empty", a_out_valid, 0);
      check("ovf_sticky", a_ovf, 1);
      a_out_ready = 0;
      a_rst = 1; tick(); a_rst = 0;
      check("ovf_cleared", a_ovf, 0);

      // DEPTH=4, OUT_REG=1: capacity and order
      b_out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         b_in_valid = 1; b_in_data = 8'(8'h30 + i);
         tick();
         check("d4_fill_count", b_count, 32'(i + 1));
      end
      b_in_valid = 0;
      check("d4_full_ready", b_in_ready, 0);
      check("d4_af", b_af, 1);
      b_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("d4_drain_valid", b_out_valid, 1);
         check("d4_drain_data", b_out_data, 32'(8'h30 + i));
         tick();
      end
      check("d4_drain_empty", b_out_valid, 0);
      check("d4_drain_count", b_count, 0);

      // Streaming wrap-around: 20 words, in_valid=out_ready=1 throughout
      for (int k = 0; k < 20; k++) words[k] = 8'(8'h51 + 7 * k);
      b_out_ready = 1;
      for (int k = 0; k < 20; k++) begin
         b_in_valid = 1; b_in_data = words[k];
         tick();
         check("stream_valid", b_out_valid, 1);
         check("stream_data", b_out_data, 32'(words[k]));
         check("stream_count", b_count, 1);
         check("stream_in_ready", b_in_ready, 1);
      end
      b_in_valid = 0;
      tick();
      check("stream_end_valid", b_out_valid, 0);
      check("stream_end_count", b_count, 0);
      b_out_ready = 0;

      // WIDTH=32, DEPTH=8: random handshakes against a queue model
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 20000) begin
         c_out_ready = 1'($urandom_range(0, 1));
         c_in_valid  = (sent < 1000) && c_in_ready && ($urandom_range(0, 3) != 0);
         c_in_data   = $urandom;
         check("rnd_valid", c_out_valid, (q.size() != 0) ? 1 : 0);
         push_m = c_in_valid && c_in_ready;
         pop_m  = c_out_valid && c_out_ready;
         if (pop_m && q.size() > 0) begin
            check("rnd_data", c_out_data, q[0]);
            void'(q.pop_front());
            got++;
         end
         if (push_m) begin
            q.push_back(c_in_data);
            sent++;
         end
         tick();
         cyc++;
         check("rnd_count", c_count, 32'(q.size()));
         check("rnd_count_max", (c_count <= 4'd8) ? 1 : 0, 1);
      end
      c_in_valid = 0; c_out_ready = 0;
      check("rnd_all_words", 32'(got), 1000);
      check("rnd_no_ovf", c_ovf, 0);

      // Reset mid-stream at count=5
      for (int i = 0; i < 5; i++) begin
         c_in_valid = 1; c_in_data = 32'hC0DE_0000 + 32'(i);
         tick();
      end
      check("mid_count5", c_count, 5);
      c_rst = 1; c_in_valid = 1; c_in_data = 32'hDEAD_BEEF; c_out_ready = 1;
      tick();
      c_rst = 0;
      check("mid_rst_count", c_count, 0);
      check("mid_rst_valid", c_out_valid, 0);
      check("mid_rst_ready", c_in_ready, 1);
      c_in_valid = 1; c_in_data = 32'h1234_5678; c_out_ready = 0;
      tick();
      c_in_valid = 0;
      check("post_rst_valid", c_out_valid, 1);
      check("post_rst_data", c_out_data, 32'h1234_5678);
      check("post_rst_count", c_count, 1);
      c_out_ready = 1;
      tick();
      c_out_ready = 0;
      check("post_rst_empty", c_out_valid, 0);
      check("post_rst_count0", c_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
